// File: rtl/dmem_if.sv
// Data-memory port between the pipeline's memory stage (master) and the
// memory responder (slave).
interface dmem_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic        dmem_busy;
  logic        proto_err;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp, dmem_err, dmem_busy, proto_err
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp, dmem_err, dmem_busy, proto_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: captures a request pulse, accesses a
// word array LATENCY cycles later and strobes dmem_resp with the word.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      dmem,
  output logic [1:0] dbg_state
);
  // Handshake: any nonzero mask for one cycle is a request, accepted in IDLE
  // or RESP; completion is a single-cycle dmem_resp exactly LATENCY cycles
  // later, with dmem_rdata/dmem_err valid in that cycle. No back-pressure.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam int         IW      = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam bit         LAT_ONE = (LATENCY == 1);

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            req, accept, proto_set, access;
  logic [29:0]     in_word;
  logic            in_oor;
  logic [IW-1:0]   in_idx;
  logic [IW-1:0]   cap_idx, a_idx;
  logic            cap_oor, a_oor;
  logic [3:0]      cap_wmask, a_wmask;
  logic [31:0]     cap_wdata, a_wdata;
  logic [31:0]     cur_word, merged;
  logic [31:0]     rdata_q;
  logic            err_q, proto_q;
  logic [31:0]     mem [MEM_WORDS];

  assign req     = (|dmem.dmem_rmask) | (|dmem.dmem_wmask);
  assign in_word = 30'((dmem.dmem_addr - BASE_ADDR) >> 2);
  assign in_oor  = {2'b00, in_word} >= 32'(MEM_WORDS);
  assign in_idx  = in_word[IW-1:0];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (req) begin
          accept   = 1'b1;
          cnt_next = LAT_M1;
          if (LAT_ONE) state_next = RESP;
          else         state_next = BUSY;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  assign proto_set = (req && state == BUSY) ||
                     (accept && (|dmem.dmem_rmask) && (|dmem.dmem_wmask));
  assign access    = (state_next == RESP);

  // With LATENCY=1 the access edge is the accept edge, so use the live request.
  assign a_idx   = LAT_ONE ? in_idx           : cap_idx;
  assign a_oor   = LAT_ONE ? in_oor           : cap_oor;
  assign a_wmask = LAT_ONE ? dmem.dmem_wmask  : cap_wmask;
  assign a_wdata = LAT_ONE ? dmem.dmem_wdata  : cap_wdata;

  assign cur_word = mem[a_idx];

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (a_wmask[i]) merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (proto_set) proto_q <= 1'b1;
      if (access) begin
        rdata_q <= a_oor ? 32'd0 : merged;
        err_q   <= a_oor;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      cap_idx   <= in_idx;
      cap_oor   <= in_oor;
      cap_wmask <= dmem.dmem_wmask;
      cap_wdata <= dmem.dmem_wdata;
    end
  end

  // Array is not reset; rst still suppresses a write on a coinciding edge.
  always_ff @(posedge clk) begin
    if (!rst && access && !a_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (a_wmask[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  assign dmem.dmem_rdata = rdata_q;
  assign dmem.dmem_resp  = (state == RESP);
  assign dmem.dmem_err   = err_q & (state == RESP);
  assign dmem.dmem_busy  = (state != IDLE);
  assign dmem.proto_err  = proto_q;
  assign dbg_state       = state;
endmodule
